// File: rtl/rect_buffer_writer.sv
// rtl/rect_buffer_writer.sv - steers a raster pixel stream into a 2x2-interleaved, 4-bank line buffer
// Tracks completed rows and back-pressures the source so rows still in use are never overwritten.
module rect_buffer_writer #(
  parameter int buffer_w    = 2048,
  parameter int buffer_h    = 32,
  parameter int buf_length  = buffer_w * buffer_h / 4,
  parameter int buf_len_log = $clog2(buf_length)
) (
  input  logic                        buf_read_clk,
  input  logic                        reset,
  input  logic [15:0]                 pix_in,
  input  logic                        pix_in_valid,
  input  logic                        pix_in_sof,
  output logic                        pix_in_ready,
  input  logic                        row_release,
  output logic [63:0]                 buf_wr_data,
  output logic [59:0]                 buf_wr_address,
  output logic [3:0]                  buf_wr_en,
  output logic [$clog2(buffer_h):0]   rows_in_use,
  output logic                        row_done,
  output logic                        sof_err
);

  localparam int W_LOG = $clog2(buffer_w);
  localparam int H_LOG = $clog2(buffer_h);
  localparam logic [H_LOG:0] ROWS_FULL = (H_LOG + 1)'(buffer_h);

  logic [W_LOG-1:0]       col_cnt_q, col_cnt_d, col_eff;
  logic [H_LOG-1:0]       row_cnt_q, row_cnt_d;
  logic [H_LOG:0]         rows_q, rows_d;
  logic [3:0]             wr_en_q, wr_en_d;
  logic [15:0]            wr_pix_q, wr_pix_d;
  logic [14:0]            wr_addr_q, wr_addr_d;
  logic                   row_done_q, row_done_d;
  logic                   sof_err_q, sof_err_d;
  logic                   accept, restart, row_end;
  logic [buf_len_log-1:0] row_part, col_part;

  assign pix_in_ready = !reset && (rows_q != ROWS_FULL);
  assign accept       = pix_in_valid && pix_in_ready;
  // A mid-row SOF restarts the same physical row at column 0.
  assign restart      = pix_in_sof && (col_cnt_q != '0);
  assign col_eff      = restart ? '0 : col_cnt_q;
  assign row_end      = accept && (&col_eff);

  assign row_part = buf_len_log'(row_cnt_q >> 1) << (W_LOG - 1);
  assign col_part = buf_len_log'(col_eff >> 1);

  always_comb begin
    col_cnt_d  = col_cnt_q;
    row_cnt_d  = row_cnt_q;
    rows_d     = rows_q;
    wr_en_d    = 4'b0000;
    wr_pix_d   = wr_pix_q;
    wr_addr_d  = wr_addr_q;
    row_done_d = 1'b0;
    sof_err_d  = 1'b0;
    if (accept) begin
      wr_en_d   = 4'b0001 << {row_cnt_q[0], col_eff[0]};
      wr_pix_d  = pix_in;
      wr_addr_d = 15'(row_part + col_part);
      sof_err_d = restart;
      col_cnt_d = col_eff + W_LOG'(1);
      if (row_end) begin
        row_cnt_d  = row_cnt_q + H_LOG'(1);
        row_done_d = 1'b1;
      end
    end
    // Simultaneous completion and release cancel out.
    if (row_end && !row_release) begin
      rows_d = rows_q + (H_LOG + 1)'(1);
    end else if (!row_end && row_release && (rows_q != '0)) begin
      rows_d = rows_q - (H_LOG + 1)'(1);
    end
  end

  always_ff @(posedge buf_read_clk) begin
    if (reset) begin
      col_cnt_q  <= '0;
      row_cnt_q  <= '0;
      rows_q     <= '0;
      wr_en_q    <= '0;
      wr_pix_q   <= '0;
      wr_addr_q  <= '0;
      row_done_q <= 1'b0;
      sof_err_q  <= 1'b0;
    end else begin
      col_cnt_q  <= col_cnt_d;
      row_cnt_q  <= row_cnt_d;
      rows_q     <= rows_d;
      wr_en_q    <= wr_en_d;
      wr_pix_q   <= wr_pix_d;
      wr_addr_q  <= wr_addr_d;
      row_done_q <= row_done_d;
      sof_err_q  <= sof_err_d;
    end
  end

  assign buf_wr_data    = {4{wr_pix_q}};
  assign buf_wr_address = {4{wr_addr_q}};
  assign buf_wr_en      = wr_en_q;
  assign rows_in_use    = rows_q;
  assign row_done       = row_done_q;
  assign sof_err        = sof_err_q;

endmodule

// File: tb/tb_rect_buffer_writer.sv
// tb/tb_rect_buffer_writer.sv - scoreboard bench for rect_buffer_writer with a reference model
// Small geometry keeps full-buffer and wrap scenarios short.
module tb_rect_buffer_writer;

  localparam int TW = 16;
  localparam int TH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pix_in;
  logic        pix_in_valid;
  logic        pix_in_sof;
  logic        pix_in_ready;
  logic        row_release;
  logic [63:0] buf_wr_data;
  logic [59:0] buf_wr_address;
  logic [3:0]  buf_wr_en;
  logic [2:0]  rows_in_use;
  logic        row_done;
  logic        sof_err;

  always #5 clk = ~clk;

  rect_buffer_writer #(.buffer_w(TW), .buffer_h(TH)) dut (
    .buf_read_clk   (clk),
    .reset          (reset),
    .pix_in         (pix_in),
    .pix_in_valid   (pix_in_valid),
    .pix_in_sof     (pix_in_sof),
    .pix_in_ready   (pix_in_ready),
    .row_release    (row_release),
    .buf_wr_data    (buf_wr_data),
    .buf_wr_address (buf_wr_address),
    .buf_wr_en      (buf_wr_en),
    .rows_in_use    (rows_in_use),
    .row_done       (row_done),
    .sof_err        (sof_err)
  );

  typedef struct {
    logic [3:0]  en;
    logic [14:0] addr;
    logic [15:0] pix;
    logic        done;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 0;
  int   m_row = 0;
  int   m_col = 0;
  int   m_rows = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances at the edge the DUT samples.
  task automatic step(input bit v, input bit sof, input bit rel, input bit rst, input logic [15:0] pix);
    bit   m_ready, acc, restart, inc;
    int   c;
    exp_t e;
    reset = rst; pix_in_valid = v; pix_in_sof = sof; row_release = rel; pix_in = pix;
    #1;
    m_ready = !rst && (m_rows != TH);
    if (mon_en) chk("ready", 64'(pix_in_ready), 64'(m_ready));
    acc = v && m_ready;
    @(posedge clk);
    if (rst) begin
      m_row = 0; m_col = 0; m_rows = 0;
    end else begin
      inc = 0;
      if (acc) begin
        restart = sof && (m_col != 0);
        c = restart ? 0 : m_col;
        e.en   = 4'(1 << ((m_row % 2) * 2 + (c % 2)));
        e.addr = 15'((m_row / 2) * (TW / 2) + c / 2);
        e.pix  = pix;
        e.done = (c == TW - 1);
        e.err  = restart;
        sb.push_back(e);
        if (c == TW - 1) begin
          m_col = 0; m_row = (m_row + 1) % TH; inc = 1;
        end else begin
          m_col = c + 1;
        end
      end
      if (inc && !rel) m_rows++;
      else if (!inc && rel && m_rows > 0) m_rows--;
    end
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("rows_in_use", 64'(rows_in_use), 64'(m_rows));
      if (buf_wr_en != 4'b0 || sb.size() != 0) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL stray_strobe: got en=%b expected none at %0t", buf_wr_en, $time);
        end else begin
          e = sb.pop_front();
          chk("wr_en", 64'(buf_wr_en), 64'(e.en));
          chk("wr_address", 64'(buf_wr_address), 64'({4{e.addr}}));
          chk("wr_data", buf_wr_data, {4{e.pix}});
          chk("row_done", 64'(row_done), 64'(e.done));
          chk("sof_err", 64'(sof_err), 64'(e.err));
        end
      end else begin
        chk("row_done_idle", 64'(row_done), 64'(0));
        chk("sof_err_idle", 64'(sof_err), 64'(0));
      end
    end
  end

  initial begin
    reset = 1; pix_in_valid = 0; pix_in_sof = 0; row_release = 0; pix_in = '0;
    @(posedge clk); #1;
    step(0, 0, 0, 1, 16'h0);
    step(0, 0, 0, 1, 16'h0);
    mon_en = 1;

    // First pixels of row 0: banks 0,1,0,1 at addresses 0,0,1,1.
    for (int i = 0; i < 4; i++) step(1, (i == 0), 0, 0, 16'(16'hA0 + i));

    // Random traffic with sparse releases so the buffer repeatedly fills.
    for (int i = 0; i < 800; i++)
      step(($urandom % 4) != 0, ($urandom % 40) == 0, ($urandom % 30) == 0, 0, 16'($urandom));

    // Hold valid high with no release until full, then stay stalled.
    for (int i = 0; i < TW * TH * 2 && m_rows != TH; i++) step(1, 0, 0, 0, 16'($urandom));
    chk("full", 64'(m_rows), 64'(TH));
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 16'($urandom));
    step(0, 0, 1, 0, 16'h0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 16'($urandom));

    // Drain, then complete a row in the same cycle as a release.
    for (int i = 0; i < TH + 1 && m_rows != 0; i++) step(0, 0, 1, 0, 16'h0);
    for (int i = 0; i < TW && m_col != TW - 1; i++) step(1, 0, 0, 0, 16'($urandom));
    step(1, 0, 1, 0, 16'hBEEF);
    step(0, 0, 1, 0, 16'h0);
    step(0, 0, 1, 0, 16'h0);

    // Mid-row SOF restarts the row at column 0.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 16'($urandom));
    step(1, 1, 0, 0, 16'h5A5A);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 16'($urandom));

    // Reset in the middle of a row.
    step(1, 0, 0, 1, 16'h1111);
    step(1, 0, 0, 1, 16'h2222);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 16'($urandom));

    for (int i = 0; i < 1200; i++)
      step(($urandom % 3) != 0, ($urandom % 25) == 0, ($urandom % 12) == 0, ($urandom % 300) == 0, 16'($urandom));

    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 16'h0);
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
